// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiters.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    // Index width for a requester vector; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester after the last grant,
// wrapping modulo N_REQ.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    int w_cand;

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = int'(i_last_grant) + off;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (!o_any && i_req_valid[w_cand]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART TX core through a 1-entry holding register.
// Optional burst watchdog enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 255,
    parameter  int TO_W    = 8,
    localparam int IDX_W   = idx_width(N_REQ)
) (
    input  logic                         CLKIN,
    input  logic                         RESET,
    input  logic                         clock_enable,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]       tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         grant_valid,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         abort
);

    if (N_REQ < 1 || TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal N_REQ/TIMEOUT/TO_W combination");
    end

    arb_state_e             r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_grant_id, w_grant_id_nxt;
    logic [IDX_W-1:0]       r_last_grant, w_last_grant_nxt;
    logic                   r_grant_valid, w_grant_valid_nxt;
    logic                   r_tx_valid, w_tx_valid_nxt;
    logic [UART_BYTE_W-1:0] r_tx_data, w_tx_data_nxt;

    logic                   w_pick_any;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_g_valid, w_g_last, w_space, w_accept, w_drain;
    logic [UART_BYTE_W-1:0] w_g_data;

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_pick_any),
        .o_idx        (w_pick_idx)
    );

    assign w_g_valid = req_valid[r_grant_id];
    assign w_g_last  = req_last[r_grant_id];
    assign w_g_data  = req_data[int'(r_grant_id)*UART_BYTE_W +: UART_BYTE_W];

    // The holding register has room if it is empty or is being emptied this cycle.
    assign w_space  = !r_tx_valid || tx_ready;
    assign w_drain  = r_tx_valid && tx_ready && clock_enable;
    assign w_accept = (r_state == ARB_BURST) && w_space && clock_enable && w_g_valid;

    always_comb begin
        req_ready = '0;
        if (r_state == ARB_BURST && w_space && clock_enable) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    logic [TO_W-1:0] r_wd, w_wd_nxt;
    logic            r_abort, w_abort_nxt;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_id_nxt    = r_grant_id;
        w_last_grant_nxt  = r_last_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_tx_valid_nxt    = r_tx_valid;
        w_tx_data_nxt     = r_tx_data;
`ifdef UART_ARB_WATCHDOG_EN
        w_wd_nxt          = r_wd;
        w_abort_nxt       = 1'b0;
`endif
        if (clock_enable) begin
            if (w_drain) begin
                w_tx_valid_nxt = 1'b0;
            end
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        w_grant_id_nxt    = w_pick_idx;
                        w_grant_valid_nxt = 1'b1;
                        w_state_nxt       = ARB_BURST;
`ifdef UART_ARB_WATCHDOG_EN
                        w_wd_nxt          = '0;
`endif
                    end
                end
                ARB_BURST: begin
                    if (w_accept) begin
                        w_tx_data_nxt  = w_g_data;
                        w_tx_valid_nxt = 1'b1;
`ifdef UART_ARB_WATCHDOG_EN
                        w_wd_nxt       = '0;
`endif
                        if (w_g_last) begin
                            w_state_nxt = ARB_DRAIN;
                        end
                    end
`ifdef UART_ARB_WATCHDOG_EN
                    // A silent requester loses the grant; the byte already held still goes out.
                    else if (!w_g_valid) begin
                        if (r_wd == TO_W'(TIMEOUT - 1)) begin
                            w_abort_nxt      = 1'b1;
                            w_state_nxt      = ARB_DRAIN;
                            w_last_grant_nxt = r_grant_id;
                        end else begin
                            w_wd_nxt = r_wd + 1'b1;
                        end
                    end
`endif
                end
                ARB_DRAIN: begin
                    if (w_space) begin
                        w_state_nxt       = ARB_IDLE;
                        w_grant_valid_nxt = 1'b0;
                        w_last_grant_nxt  = r_grant_id;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            r_state       <= ARB_IDLE;
            r_grant_id    <= '0;
            r_last_grant  <= IDX_W'(N_REQ - 1);
            r_grant_valid <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    // The abort pulse is not gated by clock_enable so it lasts exactly one CLKIN cycle.
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            r_wd    <= '0;
            r_abort <= 1'b0;
        end else begin
            r_wd    <= w_wd_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign abort = r_abort;
`else
    assign abort = 1'b0;
`endif

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_WATCHDOG_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 30;
`endif

    logic           clk;
    logic           RESET;
    logic           ce;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           abort;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .CLKIN        (clk),
        .RESET        (RESET),
        .clock_enable (ce),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .abort        (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-requester byte streams; a set pl flag marks the last byte of a packet.
    logic [7:0] pb [N][64];
    bit         pl [N][64];
    int         plen [N];
    int         ppos [N];
    logic [7:0] exp_q [$];
    int         gnt_q [$];

    task automatic clear_pkts();
        for (int k = 0; k < N; k++) begin
            plen[k] = 0;
            ppos[k] = 0;
        end
        exp_q.delete();
        gnt_q.delete();
    endtask

    task automatic add_byte(input int k, input logic [7:0] b, input bit l);
        pb[k][plen[k]] = b;
        pl[k][plen[k]] = l;
        plen[k]++;
    endtask

    task automatic add_rand_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            add_byte(k, 8'($urandom), i == len - 1);
        end
    endtask

    // Whole packets are served in round-robin order among requesters with data left.
    task automatic build_expected(input int last);
        int  ptr [N];
        int  pick;
        bit  more;
        for (int k = 0; k < N; k++) ptr[k] = 0;
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int off = 1; off <= N; off++) begin
                if (pick < 0 && ptr[(last + off) % N] < plen[(last + off) % N]) begin
                    pick = (last + off) % N;
                end
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                gnt_q.push_back(pick);
                do begin
                    exp_q.push_back(pb[pick][ptr[pick]]);
                    ptr[pick]++;
                end while (!pl[pick][ptr[pick] - 1]);
                last = pick;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        RESET     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        repeat (cycles) @(negedge clk);
        RESET = 1'b0;
    endtask

    task automatic run_traffic(input int ce_pct, input bit ce_toggle, input int rdy_pct,
                               input int stall, input int gap_pct, input int stop_after,
                               input int budget);
        int         cyc;
        int         accepted;
        bit         done;
        bit         prev_gv;
        bit         acc_pend;
        bit         first;
        logic [7:0] prev_data;
        logic [N-1:0] gm;
        cyc       = 0;
        accepted  = 0;
        done      = 1'b0;
        acc_pend  = 1'b0;
        prev_gv   = grant_valid;
        prev_data = tx_data;
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (!prev_gv && grant_valid) begin
                if (gnt_q.size() == 0) check("grant_extra", 32'(grant_id), 32'hFFFF);
                else                   check("grant_id", 32'(grant_id), 32'(gnt_q.pop_front()));
            end
            if (!acc_pend) check("tx_data_hold", 32'(tx_data), 32'(prev_data));
`ifndef UART_ARB_WATCHDOG_EN
            check("abort_low", 32'(abort), 32'd0);
`endif
            if (stop_after == 0 && exp_q.size() == 0 && gnt_q.size() == 0 && !grant_valid && !tx_valid) begin
                done = 1'b1;
            end else begin
                ce       = ce_toggle ? (cyc % 2 == 0) : ($urandom_range(99) < ce_pct);
                tx_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
                for (int k = 0; k < N; k++) begin
                    if (ppos[k] < plen[k]) begin
                        first = (ppos[k] == 0) || pl[k][ppos[k] - 1];
                        req_valid[k]      = first || ($urandom_range(99) >= gap_pct);
                        req_data[8*k +: 8] = pb[k][ppos[k]];
                        req_last[k]       = req_valid[k] ? pl[k][ppos[k]] : 1'($urandom_range(1));
                    end else begin
                        req_valid[k]      = 1'b0;
                        req_data[8*k +: 8] = 8'($urandom);
                        req_last[k]       = 1'($urandom_range(1));
                    end
                end
                #1;
                gm = '0;
                gm[grant_id] = 1'b1;
                if (!ce || (tx_valid && !tx_ready) || !grant_valid) check("rdy_zero", 32'(req_ready), 32'd0);
                else                                                check("rdy_onehot", 32'(req_ready & ~gm), 32'd0);
                acc_pend = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (req_valid[k] && req_ready[k]) begin
                        ppos[k]++;
                        accepted++;
                        acc_pend = 1'b1;
                    end
                end
                if (tx_valid && tx_ready && ce) begin
                    if (exp_q.size() == 0) check("tx_extra", 32'(tx_data), 32'hFFFF);
                    else                   check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                prev_gv   = grant_valid;
                prev_data = tx_data;
                cyc++;
                if (stop_after > 0 && accepted >= stop_after) done = 1'b1;
            end
        end
        if (!done) check("cycle_budget", 32'd0, 32'd1);
    endtask

    initial begin
        RESET     = 1'b1;
        ce        = 1'b1;
        tx_ready  = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_last  = '0;
        clear_pkts();

        // Reset held 3 cycles with every requester asking.
        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        RESET     = 1'b0;

        // Single packet from requester 1, exact cycle timing.
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_A500;
        req_last  = 4'b0000;
        @(negedge clk);
        check("sp_grant_valid", 32'(grant_valid), 32'd1);
        check("sp_grant_id", 32'(grant_id), 32'd1);
        check("sp_tx_valid0", 32'(tx_valid), 32'd0);
        check("sp_ready0", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_data = 32'h0000_3C00;
        req_last = 4'b0010;
        check("sp_byte0", 32'(tx_data), 32'hA5);
        check("sp_tx_valid1", 32'(tx_valid), 32'd1);
        #1 check("sp_ready1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        check("sp_byte1", 32'(tx_data), 32'h3C);
        check("sp_tx_valid2", 32'(tx_valid), 32'd1);
        #1 check("sp_ready_drain", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("sp_idle_tx", 32'(tx_valid), 32'd0);
        check("sp_idle_grant", 32'(grant_valid), 32'd0);

        // Round-robin: req0 twice and req2 once, req1 silent.
        do_reset(1);
        clear_pkts();
        add_byte(0, 8'h11, 1'b1);
        add_byte(0, 8'h12, 1'b1);
        add_byte(2, 8'h22, 1'b1);
        build_expected(N - 1);
        run_traffic(100, 1'b0, 100, 0, 0, 0, 500);

        // Round-robin: req1 now pending, so it is served before req0 repeats.
        do_reset(1);
        clear_pkts();
        add_byte(0, 8'h31, 1'b1);
        add_byte(0, 8'h32, 1'b1);
        add_byte(1, 8'h41, 1'b1);
        add_byte(2, 8'h51, 1'b1);
        build_expected(N - 1);
        run_traffic(100, 1'b0, 100, 0, 0, 0, 500);

        // Backpressure with clock_enable toggling every cycle.
        do_reset(1);
        clear_pkts();
        add_rand_pkt(3, 4);
        add_rand_pkt(1, 2);
        build_expected(N - 1);
        run_traffic(0, 1'b1, 100, 10, 0, 0, 500);

        // Reset after 2 of 4 bytes accepted, then fresh arbitration starts at req0.
        do_reset(1);
        clear_pkts();
        add_rand_pkt(2, 4);
        build_expected(N - 1);
        run_traffic(100, 1'b0, 100, 0, 0, 2, 500);
        do_reset(1);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_grant", 32'(grant_valid), 32'd0);
        clear_pkts();
        add_byte(3, 8'h77, 1'b1);
        add_byte(0, 8'h66, 1'b1);
        build_expected(N - 1);
        run_traffic(100, 1'b0, 100, 0, 0, 0, 500);

        // Randomized mixed traffic.
        for (int round = 0; round < 3; round++) begin
            do_reset(1);
            clear_pkts();
            for (int k = 0; k < N; k++) begin
                for (int p = 0; p < int'($urandom_range(4, 1)); p++) begin
                    add_rand_pkt(k, int'($urandom_range(8, 1)));
                end
            end
            build_expected(N - 1);
            run_traffic(60 + 15 * round, 1'b0, 50 + 20 * round, 0, GAP, 0, 20000);
        end

`ifdef UART_ARB_WATCHDOG_EN
        // Requester 1 goes silent mid-packet; requester 2 must get the next grant.
        do_reset(1);
        ce       = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        req_last  = 4'b0000;
        @(negedge clk);
        check("wd_grant1", 32'(grant_id), 32'd1);
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        req_last  = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wd_abort", 32'(abort), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("wd_abort_end", 32'(abort), 32'd0);
        @(negedge clk);
        check("wd_next_valid", 32'(grant_valid), 32'd1);
        check("wd_next_id", 32'(grant_id), 32'd2);
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        repeat (3) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
